// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the fetch stage.
// Holds the machine word type, the bubble encoding, the default reset PC,
// and the helper that forms a J-type jump target.
package pc_fetch_stage_pkg;

  typedef logic [31:0] word_t;

  // sll $0,$0,0 -- the encoding of a pipeline bubble
  localparam word_t NOP_INSTR        = 32'h0000_0000;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  // The jump target keeps the upper nibble of the delay-slot PC and
  // word-aligns the 26-bit target field.
  function automatic word_t jump_target(input word_t pcplus4, input logic [25:0] jta);
    return {pcplus4[31:28], jta, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: hazard controls, decode-stage feedback, and fetch/decode outputs.
//   master : hazard unit / decode / memory side (drives controls, reads results)
//   slave  : the fetch stage itself
interface pc_fetch_stage_if;
  import pc_fetch_stage_pkg::*;

  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  word_t       instr_f;
  word_t       immsh_d;
  logic        pcsrc_d;
  logic        jump_d;
  logic [25:0] jta_d;

  word_t       pc_f;
  word_t       pcplus4_f;
  word_t       instr_d;
  word_t       pcplus4_d;
  word_t       pcbranch_d;
  logic        valid_d;

  modport master (
    output stall_f, stall_d, flush_d, instr_f, immsh_d, pcsrc_d, jump_d, jta_d,
    input  pc_f, pcplus4_f, instr_d, pcplus4_d, pcbranch_d, valid_d
  );

  modport slave (
    input  stall_f, stall_d, flush_d, instr_f, immsh_d, pcsrc_d, jump_d, jta_d,
    output pc_f, pcplus4_f, instr_d, pcplus4_d, pcbranch_d, valid_d
  );

endinterface

// File: rtl/flopenrc.sv
// Width-parameterised register with synchronous reset, synchronous clear and enable.
// Priority on each rising clock: reset > clear > enable.
//   clk_i   : clock
//   reset_i : synchronous active-high reset, loads ResetVal
//   clr_i   : synchronous clear, loads zero
//   en_i    : load d_i
//   d_i/q_o : data in / registered data out
module flopenrc #(
  parameter int unsigned      Width    = 32,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_o <= ResetVal;
    end else if (clr_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID register.
//   clk   : rising-edge clock for all state
//   reset : synchronous active-high reset
//   bus   : fetch-stage interface (slave side)
//     in : stall_f, stall_d, flush_d, instr_f, immsh_d, pcsrc_d, jump_d, jta_d
//     out: pc_f, pcplus4_f, instr_d, pcplus4_d, pcbranch_d, valid_d
// Instruction memory is external; pc_f is its address and instr_f its data.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input logic             clk,
  input logic             reset,
  pc_fetch_stage_if.slave bus
);

  word_t pc_q;
  word_t pc_d;
  word_t pcplus4_f;
  word_t pcbranch_d;
  word_t instr_d_q;
  word_t pcplus4_d_q;
  logic  valid_d_q;

  always_comb begin
    pcplus4_f  = pc_q + 32'd4;
    pcbranch_d = pcplus4_d_q + bus.immsh_d;
  end

  // Jump wins over a simultaneous branch. A redirect presented while stall_f
  // is high is dropped here; the hazard unit is expected to hold it.
  always_comb begin
    pc_d = pcplus4_f;
    if (bus.jump_d) begin
      pc_d = jump_target(pcplus4_d_q, bus.jta_d);
    end else if (bus.pcsrc_d) begin
      pc_d = pcbranch_d;
    end
  end

  flopenrc #(
    .Width   (32),
    .ResetVal(RESET_PC)
  ) u_pc_reg (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (~bus.stall_f),
    .clr_i  (1'b0),
    .d_i    (pc_d),
    .q_o    (pc_q)
  );

  // IF/ID register: flush inserts a bubble and overrides stall_d.
  flopenrc #(
    .Width   (32),
    .ResetVal(NOP_INSTR)
  ) u_instr_d_reg (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (~bus.stall_d),
    .clr_i  (bus.flush_d),
    .d_i    (bus.instr_f),
    .q_o    (instr_d_q)
  );

  flopenrc #(
    .Width   (32),
    .ResetVal(32'h0000_0000)
  ) u_pcplus4_d_reg (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (~bus.stall_d),
    .clr_i  (bus.flush_d),
    .d_i    (pcplus4_f),
    .q_o    (pcplus4_d_q)
  );

  flopenrc #(
    .Width   (1),
    .ResetVal(1'b0)
  ) u_valid_d_reg (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (~bus.stall_d),
    .clr_i  (bus.flush_d),
    .d_i    (1'b1),
    .q_o    (valid_d_q)
  );

  assign bus.pc_f       = pc_q;
  assign bus.pcplus4_f  = pcplus4_f;
  assign bus.instr_d    = instr_d_q;
  assign bus.pcplus4_d  = pcplus4_d_q;
  assign bus.pcbranch_d = pcbranch_d;
  assign bus.valid_d    = valid_d_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  logic reset2;

  always #5 clk = ~clk;

  pc_fetch_stage_if bus ();
  pc_fetch_stage_if bus2 ();

  pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  pc_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk  (clk),
    .reset(reset2),
    .bus  (bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state of the main DUT (reset PC = 0)
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_p4d;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc_f"}, bus.pc_f, m_pc);
    check({tag, ".pcplus4_f"}, bus.pcplus4_f, m_pc + 32'd4);
    check({tag, ".instr_d"}, bus.instr_d, m_instr);
    check({tag, ".pcplus4_d"}, bus.pcplus4_d, m_p4d);
    check({tag, ".pcbranch_d"}, bus.pcbranch_d, m_p4d + bus.immsh_d);
    check({tag, ".valid_d"}, {31'b0, bus.valid_d}, {31'b0, m_valid});
  endtask

  // One clock of the main DUT: model computes the next state from the
  // architectural rules, then outputs are compared 1 time unit after the edge.
  task automatic step(input string tag);
    logic [31:0] n_pc, n_instr, n_p4d;
    logic        n_valid;
    n_pc = m_pc; n_instr = m_instr; n_p4d = m_p4d; n_valid = m_valid;
    if (reset) begin
      n_pc = 32'h0; n_instr = 32'h0; n_p4d = 32'h0; n_valid = 1'b0;
    end else begin
      if (!bus.stall_f) begin
        if (bus.jump_d)       n_pc = {m_p4d[31:28], bus.jta_d, 2'b00};
        else if (bus.pcsrc_d) n_pc = m_p4d + bus.immsh_d;
        else                  n_pc = m_pc + 32'd4;
      end
      if (bus.flush_d) begin
        n_instr = 32'h0; n_p4d = 32'h0; n_valid = 1'b0;
      end else if (!bus.stall_d) begin
        n_instr = bus.instr_f; n_p4d = m_pc + 32'd4; n_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_p4d = n_p4d; m_valid = n_valid;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.stall_f = 1'b0; bus.stall_d = 1'b0; bus.flush_d = 1'b0;
    bus.pcsrc_d = 1'b0; bus.jump_d  = 1'b0; bus.jta_d   = 26'h0;
    bus.immsh_d = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] saved_instr, saved_p4d;

    m_pc = 32'h0; m_instr = 32'h0; m_p4d = 32'h0; m_valid = 1'b0;
    idle_inputs();
    bus.instr_f = 32'h1234_5678;
    bus2.stall_f = 1'b0; bus2.stall_d = 1'b0; bus2.flush_d = 1'b0;
    bus2.pcsrc_d = 1'b0; bus2.jump_d  = 1'b0; bus2.jta_d   = 26'h0;
    bus2.immsh_d = 32'h0000_1234; bus2.instr_f = 32'hDEAD_BEEF;
    reset  = 1'b1;
    reset2 = 1'b1;

    // Reset for two cycles, then four free-running fetches
    step("rst0");
    step("rst1");
    check("rst_pc", bus.pc_f, 32'h0);
    check("rst_valid", {31'b0, bus.valid_d}, 32'h0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      r = $urandom(); bus.instr_f = r;
      step("seq");
      check("seq_pc", bus.pc_f, 32'(4 * k));
      check("seq_valid", {31'b0, bus.valid_d}, 32'h1);
    end

    // Backward branch from pcplus4_d = 0x10
    check("br_p4d", bus.pcplus4_d, 32'h0000_0010);
    bus.immsh_d = 32'hFFFF_FFF8; bus.pcsrc_d = 1'b1;
    #1;
    check("br_target", bus.pcbranch_d, 32'h0000_0008);
    step("br");
    check("br_pc", bus.pc_f, 32'h0000_0008);
    idle_inputs();

    // Branch into 0x4000_0000, then jump+branch together (jump wins)
    bus.immsh_d = 32'h4000_0000 - m_p4d; bus.pcsrc_d = 1'b1;
    step("to4");
    idle_inputs();
    check("to4_pc", bus.pc_f, 32'h4000_0000);
    step("to4b");
    check("to4_p4d", bus.pcplus4_d, 32'h4000_0004);
    bus.jump_d = 1'b1; bus.pcsrc_d = 1'b1; bus.jta_d = 26'h000_0040; bus.immsh_d = 32'h0000_0100;
    step("jmp");
    check("jmp_pc", bus.pc_f, 32'h4000_0100);
    idle_inputs();

    // Stall both stages for three cycles at 0x20
    reset = 1'b1;
    step("rst2");
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      r = $urandom(); bus.instr_f = r;
      step("run");
    end
    check("stall_pc0", bus.pc_f, 32'h0000_0020);
    saved_instr = m_instr; saved_p4d = m_p4d;
    bus.stall_f = 1'b1; bus.stall_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      r = $urandom(); bus.instr_f = r;
      step("stall");
      check("stall_pc", bus.pc_f, 32'h0000_0020);
      check("stall_instr", bus.instr_d, saved_instr);
      check("stall_p4d", bus.pcplus4_d, saved_p4d);
    end
    idle_inputs();
    step("resume");
    check("resume_pc", bus.pc_f, 32'h0000_0024);

    // Flush overrides stall_d
    bus.instr_f = 32'h8C08_0004;
    step("ld");
    check("ld_instr", bus.instr_d, 32'h8C08_0004);
    bus.flush_d = 1'b1; bus.stall_d = 1'b1;
    step("flush");
    check("flush_instr", bus.instr_d, 32'h0);
    check("flush_valid", {31'b0, bus.valid_d}, 32'h0);
    check("flush_p4d", bus.pcplus4_d, 32'h0);
    idle_inputs();

    // Redirect lost under stall_f
    bus.stall_f = 1'b1; bus.pcsrc_d = 1'b1; bus.immsh_d = 32'h0000_0400;
    saved_p4d = bus.pc_f;
    step("lost");
    check("lost_pc", bus.pc_f, saved_p4d);
    idle_inputs();

    // Reset during a redirect discards it
    bus.pcsrc_d = 1'b1; bus.immsh_d = 32'h0000_0100; reset = 1'b1;
    step("rst_br");
    check("rst_br_pc", bus.pc_f, 32'h0);
    reset = 1'b0; idle_inputs();
    step("rst_br2");
    check("rst_br_p4d", bus.pcplus4_d, 32'h0000_0004);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      r = $urandom(); bus.instr_f = r;
      r = $urandom(); bus.immsh_d = {{14{r[15]}}, r[15:0], 2'b00};
      r = $urandom(); bus.jta_d = r[25:0];
      bus.stall_f = ($urandom_range(0, 9) == 0);
      bus.stall_d = ($urandom_range(0, 9) == 0);
      bus.flush_d = ($urandom_range(0, 11) == 0);
      bus.pcsrc_d = ($urandom_range(0, 5) == 0);
      bus.jump_d  = ($urandom_range(0, 7) == 0);
      reset       = ($urandom_range(0, 49) == 0);
      step("rnd");
    end
    reset = 1'b0; idle_inputs();

    // Wrap-around instance with RESET_PC = 0xFFFF_FFFC
    @(posedge clk); #1;
    check("wrap_rst_pc", bus2.pc_f, 32'hFFFF_FFFC);
    check("wrap_rst_p4f", bus2.pcplus4_f, 32'h0);
    check("wrap_rst_br", bus2.pcbranch_d, 32'h0000_1234);
    reset2 = 1'b0;
    @(posedge clk); #1;
    check("wrap_pc", bus2.pc_f, 32'h0);
    check("wrap_p4d", bus2.pcplus4_d, 32'h0);
    check("wrap_valid", {31'b0, bus2.valid_d}, 32'h1);
    @(posedge clk); #1;
    check("wrap_pc2", bus2.pc_f, 32'h4);
    bus2.pcsrc_d = 1'b1; bus2.immsh_d = 32'h0000_0040; reset2 = 1'b1;
    @(posedge clk); #1;
    check("wrap_rst_br_pc", bus2.pc_f, 32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 stall_f  in  1  hold PC register.
REQ-005 stall_d  in  1  hold IF/ID register.
REQ-006 flush_d  in  1  clear IF/ID register (insert bubble).
REQ-007 instr_f  in  32  instruction word read from instruction memory at pc_f.
REQ-008 immsh_d  in  32  sign-extended immediate already shifted left by 2 (decode stage).
REQ-009 pcsrc_d  in  1  branch taken, resolved in decode.
REQ-010 jump_d  in  1  jump instruction in decode.
REQ-011 jta_d  in  26  jump target field instr_d[25:0].
REQ-012 pc_f  out  32  current fetch PC, drives instruction memory address.
REQ-013 pcplus4_f  out  32  pc_f + 4.
REQ-014 instr_d  out  32  IF/ID instruction.
REQ-015 pcplus4_d  out  32  IF/ID PC+4.
REQ-016 pcbranch_d  out  32  branch target.
REQ-017 valid_d  out  1  IF/ID holds a real fetched instruction, not a bubble.

Function
REQ-018 pcplus4_f SHALL equal pc_f + 32'd4, combinational, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-019 pcbranch_d SHALL equal pcplus4_d + immsh_d, combinational, 32-bit, carry-out discarded.
REQ-020 Next PC, in priority order: stall_f=1 -> hold; jump_d=1 -> {pcplus4_d[31:28], jta_d, 2'b00}; pcsrc_d=1 -> pcbranch_d; else pcplus4_f.
REQ-021 jump_d and pcsrc_d both 1 SHALL select the jump target.
REQ-022 PC register SHALL update on every rising clk with the REQ-020 value; redirect latency one cycle (target visible on pc_f the cycle after jump_d/pcsrc_d asserted with stall_f=0).
REQ-023 IF/ID priority per rising clk: flush_d=1 -> instr_d=0, pcplus4_d=0, valid_d=0; else stall_d=1 -> hold all three; else load instr_f, pcplus4_f, valid_d=1.
REQ-024 flush_d SHALL override stall_d when both are asserted.
REQ-025 A redirect asserted together with stall_f=1 SHALL be lost; the hazard unit re-presents it; no internal redirect buffering.
REQ-026 instr_d=32'h0000_0000 (sll $0,$0,0) SHALL be the bubble encoding.

Reset
REQ-027 On reset: pc_f=RESET_PC, instr_d=0, pcplus4_d=0, valid_d=0; reset overrides stall and flush.
REQ-028 Reset asserted mid-redirect SHALL discard the redirect; first fetch after reset deassertion is at RESET_PC.
REQ-029 During reset, pcplus4_f=RESET_PC+4 and pcbranch_d=immsh_d (combinational on reset state).

Structure
REQ-030 Shared package SHALL hold NOP_INSTR (32'h0) and the default RESET_PC constant.
REQ-031 One sub-module, flopenrc (width-parameterised register, sync reset, sync clear, enable; reset > clear > enable), SHALL implement the PC register (clear tied 0) and each IF/ID field.
REQ-032 No memories inside the block; instruction memory stays external.

Verification
REQ-033 Reset 2 cycles, release, 4 free cycles, instr_f arbitrary -> pc_f 0,4,8,C,10; valid_d=1 from the 2nd post-reset cycle.
REQ-034 pcplus4_d=32'h0000_0010, immsh_d=32'hFFFF_FFF8, pcsrc_d=1 -> pcbranch_d=32'h0000_0008; next pc_f=8.
REQ-035 pcplus4_d=32'h4000_0004, jta_d=26'h000_0040, jump_d=1, pcsrc_d=1 -> next pc_f=32'h4000_0100.
REQ-036 stall_f=stall_d=1 for 3 cycles at pc_f=0x20 -> pc_f, instr_d, pcplus4_d unchanged 3 cycles, resume at 0x24.
REQ-037 flush_d=stall_d=1 with instr_d=32'h8C08_0004 -> next instr_d=0, valid_d=0, pcplus4_d=0.
REQ-038 RESET_PC=32'hFFFF_FFFC, no stalls -> pc_f FFFF_FFFC then 0000_0000; reset during pcsrc_d=1 -> pc_f=RESET_PC.
